// File: rtl/input_pio_pkg.sv
// Shared constants for the debounced input PIO: register addresses,
// reset value of the rising-edge enable and the debounce counter width.
package input_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_RAW          = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN      = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN      = 3'd5;
  localparam logic [2:0] ADDR_PENDING      = 3'd6;

  // Rising edges are captured on every channel out of reset.
  localparam logic [31:0] RISE_EN_RST = 32'hFFFF_FFFF;

  // Counter width able to hold 0..cycles; never narrower than one bit so
  // the bypass configuration (cycles == 0) still has a legal vector.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles + 1) < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_pio_debounce_chan.sv
// One input channel: synchroniser chain, debounce counter holding the
// stable value, and rise/fall events derived from the next stable value.
module input_pio_debounce_chan
  import input_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  input  logic rise_en,
  input  logic fall_en,
  output logic s,
  output logic st,
  output logic rise,
  output logic fall
);

  // Terminal count: the change is accepted on the cycle the counter sits here.
  localparam logic [CNT_W-1:0] CNT_MAX =
    (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_st;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_st_next;

  assign s  = r_sync[SYNC_STAGES-1];
  assign st = r_st;

  // Shift the asynchronous input through the synchroniser flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], in_bit};
  end

  // Any return to the stable value restarts the count; the counter stops
  // at CNT_MAX and is cleared when the new value is accepted.
  always_comb begin
    w_st_next  = r_st;
    w_cnt_next = r_cnt;
    if (s == r_st) begin
      w_cnt_next = '0;
    end else if (DEBOUNCE_CYCLES == 0 || r_cnt == CNT_MAX) begin
      w_st_next  = s;
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Stable value and counter; reset discards any partial count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Events are taken from the next stable value so the capture flop sets
  // on the same edge that updates st.
  assign rise =  w_st_next & ~r_st & rise_en;
  assign fall = ~w_st_next &  r_st & fall_en;

endmodule

// File: rtl/input_pio_debounce.sv
// Avalon-MM input PIO with per-bit debounce, selectable edge capture,
// maskable level interrupt and registered 1-cycle read data.
module input_pio_debounce
  import input_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [31:0]      r_rdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_st;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_pending;
  logic [31:0]      w_rdata_next;
  logic             w_unused_wdata;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];
  // Upper write-data bits have no storage behind them.
  assign w_unused_wdata = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    input_pio_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[g]),
      .rise_en(r_rise_en[g]),
      .fall_en(r_fall_en[g]),
      .s      (w_s[g]),
      .st     (w_st[g]),
      .rise   (w_rise[g]),
      .fall   (w_fall[g])
    );
  end

  // Read/write control registers; writes to other addresses are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask    <= '0;
      r_rise_en <= RISE_EN_RST[WIDTH-1:0];
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_IRQ_MASK: r_mask    <= w_wdata;
        ADDR_RISE_EN:  r_rise_en <= w_wdata;
        ADDR_FALL_EN:  r_fall_en <= w_wdata;
        default: ;
      endcase
    end
  end

  assign w_clr = (w_wr && address == ADDR_EDGE_CAPTURE) ? w_wdata : '0;

  // Edge capture: a new event outranks a simultaneous write-one-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cap <= '0;
    else          r_cap <= (r_cap & ~w_clr) | w_rise | w_fall;
  end

  assign w_pending = r_cap & r_mask;
  assign irq       = |w_pending;

  // Read mux, evaluated every cycle regardless of chipselect.
  always_comb begin
    w_rdata_next = '0;
    case (address)
      ADDR_DATA:         w_rdata_next = 32'(w_st);
      ADDR_RAW:          w_rdata_next = 32'(w_s);
      ADDR_IRQ_MASK:     w_rdata_next = 32'(r_mask);
      ADDR_EDGE_CAPTURE: w_rdata_next = 32'(r_cap);
      ADDR_RISE_EN:      w_rdata_next = 32'(r_rise_en);
      ADDR_FALL_EN:      w_rdata_next = 32'(r_fall_en);
      ADDR_PENDING:      w_rdata_next = 32'(w_pending);
      default:           w_rdata_next = '0;
    endcase
  end

  // Registered read data gives the fixed one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rdata <= '0;
    else          r_rdata <= w_rdata_next;
  end

  assign readdata = r_rdata;

endmodule

// File: tb/tb_input_pio_debounce.sv
// Directed bench for input_pio_debounce: a 4-channel instance with an
// 8-cycle debounce and a 32-channel bypass instance share clock and reset.
module tb_input_pio_debounce;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [2:0]  a_address = '0;
  logic        a_cs = 1'b0;
  logic        a_wr_n = 1'b1;
  logic [31:0] a_wdata = '0;
  logic [3:0]  a_in = '0;
  logic [31:0] a_rdata;
  logic        a_irq;

  logic [2:0]  b_address = '0;
  logic        b_cs = 1'b0;
  logic        b_wr_n = 1'b1;
  logic [31:0] b_wdata = '0;
  logic [31:0] b_in = '0;
  logic [31:0] b_rdata;
  logic        b_irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_pio_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(a_address), .chipselect(a_cs),
    .write_n(a_wr_n), .writedata(a_wdata), .in_port(a_in),
    .readdata(a_rdata), .irq(a_irq)
  );

  input_pio_debounce #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(b_address), .chipselect(b_cs),
    .write_n(b_wr_n), .writedata(b_wdata), .in_port(b_in),
    .readdata(b_rdata), .irq(b_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit sel, input logic [2:0] addr, input logic [31:0] data);
    if (sel) begin
      b_address = addr; b_cs = 1'b1; b_wr_n = 1'b0; b_wdata = data;
    end else begin
      a_address = addr; a_cs = 1'b1; a_wr_n = 1'b0; a_wdata = data;
    end
    tick();
    a_cs = 1'b0; a_wr_n = 1'b1;
    b_cs = 1'b0; b_wr_n = 1'b1;
  endtask

  task automatic rd(input bit sel, input logic [2:0] addr, output logic [31:0] d);
    if (sel) b_address = addr;
    else     a_address = addr;
    tick();
    d = sel ? b_rdata : a_rdata;
  endtask

  logic [31:0] d;
  logic [31:0] exp_rst [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0, 32'h0};

  initial begin
    // Reset state
    #1;
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_irq", {31'b0, a_irq}, 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      rd(0, 3'(i), d);
      chk($sformatf("rst_addr%0d", i), d, exp_rst[i]);
    end
    chk("rst_irq_after", {31'b0, a_irq}, 32'h0);

    // Bounce on bit 0, then steady high
    wr(0, 3'd2, 32'h1);
    a_address = 3'd1;
    a_in = 4'h1;
    tick(); chk("raw_lag1", a_rdata, 32'h0);
    tick(); chk("raw_lag2", a_rdata, 32'h0);
    tick(); chk("raw_follow", a_rdata, 32'h1);
    repeat (2) tick();
    a_in = 4'h0;
    repeat (2) tick();
    chk("bounce_no_irq", {31'b0, a_irq}, 32'h0);
    a_in = 4'h1;
    repeat (9) tick();
    chk("deb_early", {31'b0, a_irq}, 32'h0);
    tick();
    chk("deb_exact", {31'b0, a_irq}, 32'h1);
    rd(0, 3'd0, d); chk("deb_data", d, 32'h1);
    rd(0, 3'd3, d); chk("deb_cap", d, 32'h1);
    wr(0, 3'd3, 32'h1);
    chk("deb_clr_irq", {31'b0, a_irq}, 32'h0);

    // Falling-edge capture on bit 1
    wr(0, 3'd4, 32'h0);
    wr(0, 3'd5, 32'h2);
    wr(0, 3'd2, 32'h2);
    a_in = 4'h3;
    repeat (12) tick();
    rd(0, 3'd3, d); chk("fall_rise_off", d, 32'h0);
    a_in = 4'h1;
    repeat (9) tick();
    chk("fall_early", {31'b0, a_irq}, 32'h0);
    tick();
    chk("fall_irq", {31'b0, a_irq}, 32'h1);
    rd(0, 3'd6, d); chk("fall_pending", d, 32'h2);
    rd(0, 3'd3, d); chk("fall_cap", d, 32'h2);
    wr(0, 3'd3, 32'h2);
    chk("fall_clr_irq", {31'b0, a_irq}, 32'h0);

    // W1C colliding with a new rising event on bit 0
    wr(0, 3'd4, 32'h1);
    wr(0, 3'd2, 32'h1);
    a_in = 4'h0;
    repeat (12) tick();
    chk("coll_fall_off", {31'b0, a_irq}, 32'h0);
    a_in = 4'h1;
    repeat (9) tick();
    chk("coll_pre", {31'b0, a_irq}, 32'h0);
    wr(0, 3'd3, 32'h1);
    chk("coll_irq", {31'b0, a_irq}, 32'h1);
    rd(0, 3'd3, d); chk("coll_cap", d, 32'h1);
    wr(0, 3'd3, 32'h1);
    chk("coll_clr", {31'b0, a_irq}, 32'h0);

    // Inputs held high through reset
    reset_n = 1'b0;
    a_in = 4'hF;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (12) tick();
    rd(0, 3'd3, d); chk("hold_cap", d, 32'hF);
    wr(0, 3'd2, 32'hF);
    chk("hold_irq", {31'b0, a_irq}, 32'h1);
    rd(0, 3'd3, d); chk("hold_rd", d, 32'hF);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rdata", a_rdata, 32'h0);
    chk("async_irq", {31'b0, a_irq}, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (5) tick();
    reset_n = 1'b0;
    a_in = 4'h0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (15) tick();
    rd(0, 3'd3, d); chk("midcnt_cap", d, 32'h0);
    rd(0, 3'd0, d); chk("midcnt_data", d, 32'h0);

    // 32-bit bypass instance
    rd(1, 3'd4, d); chk("b_rise_rst", d, 32'hFFFF_FFFF);
    wr(1, 3'd2, 32'h8000_0000);
    b_in = 32'h8000_0000;
    repeat (2) tick();
    chk("b_early", {31'b0, b_irq}, 32'h0);
    tick();
    chk("b_irq", {31'b0, b_irq}, 32'h1);
    rd(1, 3'd3, d); chk("b_cap", d, 32'h8000_0000);
    wr(1, 3'd0, 32'hFFFF_FFFF);
    wr(1, 3'd1, 32'hFFFF_FFFF);
    wr(1, 3'd6, 32'hFFFF_FFFF);
    rd(1, 3'd0, d); chk("b_data_ro", d, 32'h8000_0000);
    rd(1, 3'd1, d); chk("b_raw_ro", d, 32'h8000_0000);
    rd(1, 3'd6, d); chk("b_pend_ro", d, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
